// File: rtl/lvds_tx_framer.sv
// TX framer: lock wait, training, sync, then header/payload/checksum lane beats into the serializer.
// Latency: every output is registered; a FIFO word reaches tx_in one cycle after capture (header beat first).
// Backpressure: the FIFO is popped only in a header cycle with RDY_enq_tx and far-end ready, otherwise an idle frame goes out.
module lvds_tx_framer #(
   parameter int                DATA_W        = 32,
   parameter int                LANE_W        = 8,
   parameter logic [LANE_W-1:0] TRAIN_PAT     = 8'h35,
   parameter logic [LANE_W-1:0] SYNC_PAT      = 8'h77,
   parameter logic [LANE_W-1:0] DATA_HDR      = 8'hA5,
   parameter logic [LANE_W-1:0] IDLE_HDR      = 8'h5A,
   parameter int                CHK_EN        = 1,
   parameter int                RESYNC_FRAMES = 64
) (
   input  logic              tx_inclock,
   input  logic              reset,
   input  logic              tx_locked,
   input  logic              rdy_from_recv,
   input  logic [DATA_W-1:0] enq_tx,
   input  logic              RDY_enq_tx,
   output logic              EN_enq_tx,
   output logic [LANE_W-1:0] tx_in,
   output logic              link_up,
   output logic [15:0]       frames_sent
);

   localparam int BEATS = DATA_W / LANE_W;
   localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BC_W-1:0] LAST_BEAT   = BC_W'(BEATS - 1);
   localparam logic [15:0]     RESYNC_LAST = 16'(RESYNC_FRAMES - 1);

   localparam logic [2:0] S_WAIT_LOCK = 3'd0;
   localparam logic [2:0] S_TRAIN     = 3'd1;
   localparam logic [2:0] S_SYNC      = 3'd2;
   localparam logic [2:0] S_HDR       = 3'd3;
   localparam logic [2:0] S_PAYLOAD   = 3'd4;
   localparam logic [2:0] S_CHK       = 3'd5;

   // Payload must split into a whole number of lanes.
   if ((DATA_W % LANE_W) != 0 || DATA_W < LANE_W) begin : g_bad_width
      $error("lvds_tx_framer: DATA_W must be a non-zero multiple of LANE_W");
   end

   // The state register names the beat currently on tx_in.
   logic [2:0]        state,     state_nxt;
   logic [DATA_W-1:0] sr,        sr_nxt;
   logic [LANE_W-1:0] chk,       chk_nxt;
   logic [BC_W-1:0]   beat_cnt,  beat_nxt;
   logic [15:0]       rs_cnt,    rs_nxt;
   logic [15:0]       fs_nxt;
   logic [LANE_W-1:0] tx_nxt;
   logic              en_nxt;
   logic              link_nxt;
   logic              go_hdr;
   logic              frame_end;
   logic              hdr_take;
   logic [LANE_W-1:0] lane;

   assign lane     = sr[DATA_W-1 -: LANE_W];
   assign hdr_take = RDY_enq_tx & rdy_from_recv;

   // Next-state and next-beat selection; all results are registered below.
   always_comb begin
      state_nxt = state;
      tx_nxt    = '0;
      en_nxt    = 1'b0;
      sr_nxt    = sr;
      chk_nxt   = chk;
      beat_nxt  = beat_cnt;
      rs_nxt    = rs_cnt;
      fs_nxt    = frames_sent;
      go_hdr    = 1'b0;
      frame_end = 1'b0;
      link_nxt  = 1'b0;

      if (!tx_locked) begin
         // Loss of lock abandons whatever frame is in flight.
         state_nxt = S_WAIT_LOCK;
         sr_nxt    = '0;
         chk_nxt   = '0;
         beat_nxt  = '0;
      end else begin
         case (state)
            S_WAIT_LOCK: begin
               state_nxt = S_TRAIN;
               tx_nxt    = TRAIN_PAT;
            end
            S_TRAIN: begin
               if (rdy_from_recv) begin
                  state_nxt = S_SYNC;
                  tx_nxt    = SYNC_PAT;
               end else begin
                  tx_nxt    = TRAIN_PAT;
               end
            end
            S_SYNC: begin
               rs_nxt = '0;
               go_hdr = 1'b1;
            end
            S_HDR: begin
               state_nxt = S_PAYLOAD;
               beat_nxt  = '0;
               tx_nxt    = lane;
               chk_nxt   = chk ^ lane;
               sr_nxt    = sr << LANE_W;
            end
            S_PAYLOAD: begin
               if (beat_cnt == LAST_BEAT) begin
                  if (CHK_EN != 0) begin
                     state_nxt = S_CHK;
                     tx_nxt    = chk;
                  end else begin
                     frame_end = 1'b1;
                  end
               end else begin
                  beat_nxt = beat_cnt + BC_W'(1);
                  tx_nxt   = lane;
                  chk_nxt  = chk ^ lane;
                  sr_nxt   = sr << LANE_W;
               end
            end
            S_CHK: begin
               frame_end = 1'b1;
            end
            default: begin
               state_nxt = S_WAIT_LOCK;
            end
         endcase

         // Frame boundary: far-end loss beats periodic re-sync, which beats the next frame.
         if (frame_end) begin
            rs_nxt = rs_cnt + 16'd1;
            if (!rdy_from_recv) begin
               state_nxt = S_TRAIN;
               tx_nxt    = TRAIN_PAT;
            end else if (RESYNC_FRAMES != 0 && rs_cnt == RESYNC_LAST) begin
               state_nxt = S_SYNC;
               tx_nxt    = SYNC_PAT;
            end else begin
               go_hdr = 1'b1;
            end
         end

         // Header beat: take the FIFO head if possible, otherwise send an idle frame.
         if (go_hdr) begin
            state_nxt = S_HDR;
            chk_nxt   = '0;
            if (hdr_take) begin
               tx_nxt = DATA_HDR;
               en_nxt = 1'b1;
               sr_nxt = enq_tx;
               fs_nxt = frames_sent + 16'd1;
            end else begin
               tx_nxt = IDLE_HDR;
               sr_nxt = '0;
            end
         end
      end

      link_nxt = (state_nxt == S_HDR) || (state_nxt == S_PAYLOAD) || (state_nxt == S_CHK);
   end

   // State, datapath and output registers with asynchronous clear.
   always_ff @(posedge tx_inclock or posedge reset) begin
      if (reset) begin
         state       <= S_WAIT_LOCK;
         sr          <= '0;
         chk         <= '0;
         beat_cnt    <= '0;
         rs_cnt      <= '0;
         tx_in       <= '0;
         EN_enq_tx   <= 1'b0;
         link_up     <= 1'b0;
         frames_sent <= '0;
      end else begin
         state       <= state_nxt;
         sr          <= sr_nxt;
         chk         <= chk_nxt;
         beat_cnt    <= beat_nxt;
         rs_cnt      <= rs_nxt;
         tx_in       <= tx_nxt;
         EN_enq_tx   <= en_nxt;
         link_up     <= link_nxt;
         frames_sent <= fs_nxt;
      end
   end

endmodule
